// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, BURST, HOLD} arb_state_t;

    localparam int DEFAULT_DATA_W = 8;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(start) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers,
// with bounded bursts and full/almost-full throttling.
//   state | meaning
//   IDLE  | no owner; pick from rr_ptr when anything is valid
//   BURST | owner streams words until MAX_BURST or it drops valid
//   HOLD  | owner latched, waiting for FIFO space; no accepts
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    input  logic                      fifo_alm_full,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_wrdata,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;

    logic             space;
    logic             owner_valid;
    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             take_pick;
    logic             accept;
    logic [IDX_W-1:0] acc_idx;
    logic [DATA_W-1:0] sel_data;
    logic [N_REQ-1:0] ready_vec;

    // Second term covers the write already on its way into the FIFO this cycle.
    assign space       = !fifo_full && !(fifo_alm_full && fifo_wren);
    assign owner_valid = req_valid[owner];
    assign owner_inc   = IDX_W'(next_idx(int'(owner), N_REQ));
    assign pick_start  = (state == IDLE) ? rr_ptr : owner_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = burst_cnt;
        accept     = 1'b0;
        acc_idx    = owner;
        take_pick  = 1'b0;

        case (state)
            IDLE: begin
                take_pick = 1'b1;
            end
            BURST: begin
                if (owner_valid && space && burst_cnt < CNT_W'(MAX_BURST)) begin
                    accept  = 1'b1;
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end else if (!space && owner_valid) begin
                    state_nxt = HOLD;
                end else begin
                    rr_ptr_nxt = owner_inc;
                    take_pick  = 1'b1;
                end
            end
            HOLD: begin
                if (!owner_valid) begin
                    rr_ptr_nxt = owner_inc;
                    take_pick  = 1'b1;
                end else if (space) begin
                    state_nxt = BURST;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A fresh pick without space parks in HOLD with an empty burst count.
        if (take_pick) begin
            if (pick_found) begin
                owner_nxt = pick_idx;
                if (space) begin
                    accept    = 1'b1;
                    acc_idx   = pick_idx;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = BURST;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (acc_idx == IDX_W'(k)) begin
                ready_vec[k] = accept;
                sel_data     = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = rst ? '0 : ready_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            fifo_wren   <= 1'b0;
            fifo_wrdata <= '0;
            grant_id    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= cnt_nxt;
            fifo_wren <= accept;
            if (accept) begin
                fifo_wrdata <= sel_data;
                grant_id    <= acc_idx;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer streams with hand-built expected write order.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int DATA_W    = 8;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_alm_full;
    logic                    fifo_wren;
    logic [DATA_W-1:0]       fifo_wrdata;
    logic [1:0]              grant_id;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t             exp_q[$];
    logic [7:0]       prod_q[N_REQ][$];
    logic [N_REQ-1:0] mute;
    int               checks   = 0;
    int               failures = 0;

    fifo_wr_arbiter #(
        .DATA_W    (DATA_W),
        .N_REQ     (N_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_alm_full (fifo_alm_full),
        .fifo_wren     (fifo_wren),
        .fifo_wrdata   (fifo_wrdata),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N_REQ; k++) begin
            if (prod_q[k].size() > 0 && !mute[k]) begin
                req_valid[k]                  = 1'b1;
                req_data[k*DATA_W +: DATA_W]  = prod_q[k][0];
            end else begin
                req_valid[k]                  = 1'b0;
                req_data[k*DATA_W +: DATA_W]  = '0;
            end
        end
    endtask

    // Handshake sampled mid-cycle; producers advance just after the edge.
    task automatic tick();
        logic [N_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (acc[k]) void'(prod_q[k].pop_front());
        end
        drive_reqs();
    endtask

    task automatic load(input int k, input logic [7:0] base, input int n);
        for (int j = 0; j < n; j++) prod_q[k].push_back(base + 8'(j));
    endtask

    task automatic expect_words(input int k, input logic [7:0] base, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.id   = 2'(k);
            e.data = base + 8'(j);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic stream_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            check(name, fifo_wren, 1);
            tick();
        end
        check({name, "_end"}, fifo_wren, 0);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        mute          = '0;
        for (int k = 0; k < N_REQ; k++) prod_q[k].delete();
        exp_q.delete();
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("ready_onehot0", $onehot0(req_ready), 1);
            if (fifo_full || (fifo_alm_full && fifo_wren)) check("ready_no_space", req_ready, 0);
            if (fifo_wren) begin
                check("no_write_when_full", fifo_full, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", grant_id, fifo_wrdata);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_id", grant_id, e.id);
                    check("wrdata", fifo_wrdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        mute          = '0;
        req_valid     = '0;
        req_data      = '0;
        #2;
        check("rst_wren", fifo_wren, 0);
        check("rst_wrdata", fifo_wrdata, 0);
        check("rst_gid", grant_id, 0);
        check("rst_ready", req_ready, 0);
        check("rst_state", dut.state, IDLE);

        // single requester streams across burst boundaries with no gap
        apply_reset();
        load(0, 8'h01, 10);
        expect_words(0, 8'h01, 10);
        drive_reqs();
        tick();
        stream_check("t1_stream", 10);
        wait_drain("t1_drain", 40);

        // all requesters valid: 4-word bursts in rotation, no gap
        apply_reset();
        for (int k = 0; k < N_REQ; k++) load(k, 8'(k * 16), 8);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N_REQ; k++) expect_words(k, 8'(k * 16 + r * 4), 4);
        drive_reqs();
        tick();
        stream_check("t2_stream", 32);
        wait_drain("t2_drain", 80);

        // almost-full with write in flight -> HOLD, burst count frozen
        apply_reset();
        load(0, 8'h50, 6);
        expect_words(0, 8'h50, 6);
        drive_reqs();
        tick();
        fifo_alm_full = 1'b1;
        #1;
        check("t3_ready_alm", req_ready, 0);
        tick();
        check("t3_hold", dut.state, HOLD);
        check("t3_cnt_frozen", dut.burst_cnt, 1);
        fifo_full = 1'b1;
        repeat (3) begin
            #1;
            check("t3_ready_full", req_ready, 0);
            tick();
        end
        check("t3_still_hold", dut.state, HOLD);
        fifo_full     = 1'b0;
        fifo_alm_full = 1'b0;
        #1;
        check("t3_hold_no_accept", req_ready, 0);
        tick();
        check("t3_resume_ready", req_ready, 4'b0001);
        tick();
        check("t3_cnt_cont", dut.burst_cnt, 2);
        wait_drain("t3_drain", 40);

        // full held 20 cycles with everyone valid
        apply_reset();
        fifo_full = 1'b1;
        for (int k = 0; k < N_REQ; k++) load(k, 8'(8'h80 + k * 16), 2);
        drive_reqs();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_ready", req_ready, 0);
            check("t4_wren", fifo_wren, 0);
        end
        fifo_full = 1'b0;
        for (int k = 0; k < N_REQ; k++) expect_words(k, 8'(8'h80 + k * 16), 2);
        wait_drain("t4_drain", 40);

        // owner 2 drops mid-burst: 3 takes over the same cycle, then 0, then 2 resumes
        apply_reset();
        load(2, 8'h20, 4);
        expect_words(2, 8'h20, 2);
        expect_words(3, 8'h30, 4);
        expect_words(0, 8'h00, 4);
        expect_words(2, 8'h22, 2);
        drive_reqs();
        tick();
        tick();
        load(0, 8'h00, 4);
        load(3, 8'h30, 4);
        mute[2] = 1'b1;
        drive_reqs();
        #1;
        check("t5_switch", req_ready, 4'b1000);
        tick();
        tick();
        mute[2] = 1'b0;
        drive_reqs();
        wait_drain("t5_drain", 40);

        // reset during the third word of a burst
        apply_reset();
        load(1, 8'h10, 6);
        expect_words(1, 8'h10, 1);
        drive_reqs();
        tick();
        tick();
        check("t6_pre_gid", grant_id, 1);
        check("t6_pre_ready", req_ready, 4'b0010);
        rst = 1'b1;
        #1;
        check("t6_rst_wren", fifo_wren, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_gid", grant_id, 0);
        check("t6_lost_words", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(0, 8'h00, 2);
        expect_words(0, 8'h00, 2);
        expect_words(1, 8'h12, 4);
        drive_reqs();
        #1;
        check("t6_first_grant", req_ready, 4'b0001);
        wait_drain("t6_drain", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
